// File: rtl/bit_unstuffer_if.sv
// Serial stream bundle between the NRZI decoder side (master) and the bit unstuffer (slave).
// stuff_err exists only when BITUNSTUFF_ERR_EN is defined.
interface bit_unstuffer_if;
    logic abort;
    logic s_in;
    logic start_unstuffer;
    logic end_unstuffer;
    logic s_out;
    logic start_decode;
    logic end_decode;
    logic bitUnstuff_wait;
`ifdef BITUNSTUFF_ERR_EN
    logic stuff_err;

    modport master (
        output abort, s_in, start_unstuffer, end_unstuffer,
        input  s_out, start_decode, end_decode, bitUnstuff_wait, stuff_err
    );
    modport slave (
        input  abort, s_in, start_unstuffer, end_unstuffer,
        output s_out, start_decode, end_decode, bitUnstuff_wait, stuff_err
    );
`else
    modport master (
        output abort, s_in, start_unstuffer, end_unstuffer,
        input  s_out, start_decode, end_decode, bitUnstuff_wait
    );
    modport slave (
        input  abort, s_in, start_unstuffer, end_unstuffer,
        output s_out, start_decode, end_decode, bitUnstuff_wait
    );
`endif
endinterface

// File: rtl/bit_unstuffer.sv
// USB receive bit unstuffer: marks the bit after six ones as a wait slot, 2-cycle latency.
// Define BITUNSTUFF_ERR_EN to flag a 1 in the stuffed position on stuff_err and drop the packet.
module bit_unstuffer (
    input logic            clk,
    input logic            rst_n,
    bit_unstuffer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

    state_e     state_q, state_d;
    logic [2:0] ones_q, ones_d;
    logic       bit1_q, bit1_d, wait1_q, wait1_d;
    logic       s_out_q, s_out_d, wait_q, wait_d;
    logic       start_q, start_d, end_q, end_d;
    logic       take, stuffed, violation;

    assign stuffed = (ones_q == 3'd6);

`ifdef BITUNSTUFF_ERR_EN
    logic err1_q, err_q;

    assign violation = stuffed & bus.s_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err1_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err1_q <= !bus.abort && take && violation;
            err_q  <= !bus.abort && err1_q;
        end
    end

    assign bus.stuff_err = err_q;
`else
    assign violation = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        bit1_d  = 1'b0;
        wait1_d = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start_unstuffer) begin
                    state_d = StActive;
                    start_d = 1'b1;
                    take    = 1'b1;
                end
            end
            StActive: begin
                if (bus.end_unstuffer) begin
                    state_d = StFlush;
                    ones_d  = 3'd0;
                end else begin
                    take = 1'b1;
                end
            end
            StFlush: begin
                // end_q doubles as the "second flush cycle" marker
                if (end_q) state_d = StIdle;
                else       end_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            bit1_d  = bus.s_in;
            wait1_d = stuffed;
            ones_d  = (stuffed || !bus.s_in) ? 3'd0 : ones_q + 3'd1;
            if (violation) state_d = StIdle;
        end

        s_out_d = bit1_q;
        wait_d  = wait1_q;

        if (bus.abort) begin
            state_d = StIdle;
            ones_d  = 3'd0;
            bit1_d  = 1'b0;
            wait1_d = 1'b0;
            s_out_d = 1'b0;
            wait_d  = 1'b0;
            start_d = 1'b0;
            end_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ones_q  <= 3'd0;
            bit1_q  <= 1'b0;
            wait1_q <= 1'b0;
            s_out_q <= 1'b0;
            wait_q  <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            bit1_q  <= bit1_d;
            wait1_q <= wait1_d;
            s_out_q <= s_out_d;
            wait_q  <= wait_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign bus.s_out           = s_out_q;
    assign bus.bitUnstuff_wait = wait_q;
    assign bus.start_decode    = start_q;
    assign bus.end_decode      = end_q;
endmodule

// File: tb/tb_bit_unstuffer.sv
// Randomized bench for bit_unstuffer: a per-cycle expected timeline built from the stuffing rules.
// Build with BITUNSTUFF_ERR_EN to cover the stuff_err variant.
module tb_bit_unstuffer;
    localparam int MaxC = 4096;
`ifdef BITUNSTUFF_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit_unstuffer_if bus ();
    bit_unstuffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic err_sig;
`ifdef BITUNSTUFF_ERR_EN
    assign err_sig = bus.stuff_err;
`else
    assign err_sig = 1'b0;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus and expected timeline, indexed by cycle
    bit d_start[MaxC], d_end[MaxC], d_abort[MaxC], d_sin[MaxC];
    bit e_sout[MaxC], e_wait[MaxC], e_sd[MaxC], e_ed[MaxC], e_err[MaxC];
    bit a_sout[MaxC], a_wait[MaxC], a_sd[MaxC], a_ed[MaxC], a_err[MaxC];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    // Packet of n bits starting at cycle k, bit i = v[n-1-i]; ab >= 0 aborts in that cycle.
    task automatic plan(input int k, input logic [63:0] v, input int n, input int ab,
                        output int next_free);
        int  ones;
        bit  trunc;
        bit  b;
        int  slot;
        ones  = 0;
        trunc = 1'b0;
        d_start[k] = 1'b1;
        e_sd[k+1]  = 1'b1;
        for (int i = 0; i < n; i++) begin
            b = v[n-1-i];
            if (ab < 0 || k + i < ab) d_sin[k+i] = b;
            if (!trunc) begin
                slot = k + 2 + i;
                e_sout[slot] = b;
                e_wait[slot] = (ones == 6);
                if (ones == 6) begin
                    if (b && ErrEn) begin
                        e_err[slot] = 1'b1;
                        trunc = 1'b1;
                    end
                    ones = 0;
                end else begin
                    ones = b ? ones + 1 : 0;
                end
            end
        end
        if (n >= 3 && (ab < 0 || ab >= k + 2)) d_start[k+2] = 1'b1;  // ignored while active
        if (ab < 0 || ab >= k + n) d_end[k+n] = 1'b1;
        if (!trunc) e_ed[k+n+2] = 1'b1;
        if (ab >= 0) begin
            d_abort[ab] = 1'b1;
            for (int c = ab + 1; c <= k + n + 2; c++) begin
                e_sout[c] = 1'b0; e_wait[c] = 1'b0; e_sd[c] = 1'b0;
                e_ed[c] = 1'b0; e_err[c] = 1'b0;
            end
            next_free = ab + 2;
        end else begin
            next_free = k + n + 3;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && cyc < MaxC) begin
            a_sout[cyc] = bus.s_out;
            a_wait[cyc] = bus.bitUnstuff_wait;
            a_sd[cyc]   = bus.start_decode;
            a_ed[cyc]   = bus.end_decode;
            a_err[cyc]  = err_sig;
            chk("s_out", cyc, int'(bus.s_out), int'(e_sout[cyc]));
            chk("wait", cyc, int'(bus.bitUnstuff_wait), int'(e_wait[cyc]));
            chk("start_decode", cyc, int'(bus.start_decode), int'(e_sd[cyc]));
            chk("end_decode", cyc, int'(bus.end_decode), int'(e_ed[cyc]));
`ifdef BITUNSTUFF_ERR_EN
            chk("stuff_err", cyc, int'(err_sig), int'(e_err[cyc]));
`endif
        end
    end

    initial begin
        int t, nf, k1, k2, k3, k4, k5, t_end, n, ab, g, acc, cnt;
        logic [63:0] v;

        for (int c = 0; c < MaxC; c++) d_sin[c] = 1'($urandom);

        t = 20;
        k1 = t; plan(k1, 64'b10100011, 8, -1, nf);              t = nf + 2;
        k2 = t; plan(k2, 64'b111111001, 9, -1, nf);             t = nf;
        k3 = t; plan(k3, 64'b1111110111111, 13, -1, nf);        t = nf;
        k4 = t; plan(k4, 64'b1111111, 7, -1, nf);               t = nf + 1;
        k5 = t; plan(k5, 64'hBEEF, 16, k5 + 4, nf);             t = nf;
        plan(t, 64'b11011110, 8, -1, nf);                       t = nf;
        for (int p = 0; p < 40 && t < MaxC - 120; p++) begin
            n  = $urandom_range(1, 40);
            v  = {$urandom, $urandom} | {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) v = v | {$urandom, $urandom};
            ab = ($urandom_range(0, 5) == 0) ? t + $urandom_range(0, n + 1) : -1;
            plan(t, v, n, ab, nf);
            g = $urandom_range(0, 3);
            if (g > 0) d_end[nf] = 1'b1;  // stray end while idle
            t = nf + g;
        end
        t_end = t + 10;

        bus.abort = 1'b0; bus.s_in = 1'b0; bus.start_unstuffer = 1'b0; bus.end_unstuffer = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_out", 0, int'(bus.s_out), 0);
        chk("rst_wait", 0, int'(bus.bitUnstuff_wait), 0);
        chk("rst_start_decode", 0, int'(bus.start_decode), 0);
        chk("rst_end_decode", 0, int'(bus.end_decode), 0);
        chk("rst_stuff_err", 0, int'(err_sig), 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        while (cyc < t_end) begin
            @(posedge clk);
            #1;
            bus.start_unstuffer = d_start[cyc];
            bus.end_unstuffer   = d_end[cyc];
            bus.abort           = d_abort[cyc];
            bus.s_in            = d_sin[cyc];
        end
        @(negedge clk);
        cmp_en = 1'b0;

        // directed packets pinned to hand-derived values
        chk("p1_start", k1 + 1, int'(a_sd[k1+1]), 1);
        acc = 0; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            acc = (acc << 1) | int'(a_sout[k1+2+i]);
            cnt += int'(a_wait[k1+2+i]);
        end
        chk("p1_data", k1, acc, 8'b10100011);
        chk("p1_wait", k1, cnt, 0);
        chk("p1_end", k1 + 10, int'(a_ed[k1+10]), 1);

        acc = 0; cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cnt = (cnt << 1) | int'(a_wait[k2+2+i]);
            if (!a_wait[k2+2+i]) acc = (acc << 1) | int'(a_sout[k2+2+i]);
        end
        chk("p2_wait", k2, cnt, 9'b000000100);
        chk("p2_data", k2, acc, 8'b11111101);
        chk("p2_end", k2 + 11, int'(a_ed[k2+11]), 1);

        cnt = 0; acc = 0;
        for (int c = k3 + 2; c <= k3 + 14; c++) begin
            cnt += int'(a_wait[c]);
            acc += int'(a_err[c]);
        end
        chk("p3_wait_count", k3, cnt, 1);
        chk("p3_wait_slot", k3 + 8, int'(a_wait[k3+8]), 1);
        chk("p3_err_count", k3, acc, 0);
        chk("p3_end", k3 + 15, int'(a_ed[k3+15]), 1);

        chk("p4_wait", k4 + 8, int'(a_wait[k4+8]), 1);
        cnt = 0;
        for (int c = k4; c <= k4 + 12; c++) cnt += int'(a_ed[c]);
`ifdef BITUNSTUFF_ERR_EN
        chk("p4_err", k4 + 8, int'(a_err[k4+8]), 1);
        chk("p4_no_end", k4, cnt, 0);
`else
        chk("p4_end", k4 + 9, int'(a_ed[k4+9]), 1);
        chk("p4_end_count", k4, cnt, 1);
`endif

        acc = 0;
        for (int c = k5 + 5; c <= k5 + 7; c++)
            acc += int'(a_sout[c]) + int'(a_wait[c]) + int'(a_ed[c]);
        chk("p5_quiet", k5 + 5, acc, 0);
        chk("p5_restart", k5 + 7, int'(a_sd[k5+7]), 1);
        cnt = 0;
        for (int c = k5 + 5; c <= k5 + 19; c++) cnt += int'(a_ed[c]);
        chk("p5_end_count", k5, cnt, 1);
        chk("p5_end", k5 + 16, int'(a_ed[k5+16]), 1);

        // asynchronous reset in the middle of a packet
        @(posedge clk); #1;
        bus.start_unstuffer = 1'b1; bus.s_in = 1'b1; bus.abort = 1'b0; bus.end_unstuffer = 1'b0;
        @(posedge clk); #1;
        bus.start_unstuffer = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("async_pre_s_out", cyc, int'(bus.s_out), 1);
        rst_n = 1'b0;
        #1;
        chk("async_s_out", cyc, int'(bus.s_out), 0);
        chk("async_wait", cyc, int'(bus.bitUnstuff_wait), 0);
        chk("async_start_decode", cyc, int'(bus.start_decode), 0);
        chk("async_end_decode", cyc, int'(bus.end_decode), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
